// File: rtl/core_pkg.sv
// Shared definitions for the boot-stage program loader.
//   loader_cmd_e   : header command field encoding (bits [31:30] of a header word)
//   loader_state_e : loader FSM states
//   cmd_to_sel     : maps a load command onto the memory select bundle
//                    (bit0 = IM, bit1 = DM)
package core_pkg;

  localparam int unsigned HDR_CMD_MSB = 31;
  localparam int unsigned HDR_CMD_LSB = 30;

  typedef enum logic [1:0] {
    CMD_IM    = 2'b00,
    CMD_DM    = 2'b01,
    CMD_BOTH  = 2'b10,
    CMD_START = 2'b11
  } loader_cmd_e;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    WAIT  = 3'd4,
    RUN   = 3'd5
  } loader_state_e;

  function automatic logic [1:0] cmd_to_sel(input loader_cmd_e cmd);
    case (cmd)
      CMD_IM:   cmd_to_sel = 2'b01;
      CMD_DM:   cmd_to_sel = 2'b10;
      CMD_BOTH: cmd_to_sel = 2'b11;
      default:  cmd_to_sel = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-stage program loader. Parses a 32-bit valid/ready stream of load
// packets (header, length, data words) and writes the data into IM, DM or
// both through a registered write bundle. Holds Core in reset until a START
// packet arrives, then releases it START_DLY cycles later.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   s_valid/s_ready stream handshake; s_data word; s_last ends a packet
//   mem_we          one-cycle write strobe per data word
//   mem_sel         bit0 = IM, bit1 = DM
//   mem_addr        word-aligned byte address; mem_wdata little-endian word
//   core_rst        active-low reset to Core
//   load_err        sticky protocol error
//   words_loaded    saturating count of words written since reset
module prog_loader
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned START_DLY = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              load_err,
  output logic [CNT_W-1:0]  words_loaded
);

  loader_state_e     state, state_d;
  loader_cmd_e       cmd, cmd_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic [7:0]        dly_cnt, dly_cnt_d;

  logic              s_ready_d, mem_we_d, core_rst_d, load_err_d;
  logic [1:0]        mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic [CNT_W-1:0]  words_loaded_d;

  logic              accept;
  loader_cmd_e       hdr_cmd;
  logic [CNT_W-1:0]  len_n;

  assign accept  = s_valid && s_ready;
  assign hdr_cmd = loader_cmd_e'(s_data[HDR_CMD_MSB:HDR_CMD_LSB]);
  assign len_n   = s_data[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= HDR;
      cmd          <= CMD_IM;
      addr         <= '0;
      remaining    <= '0;
      dly_cnt      <= '0;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      mem_sel      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rst     <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_d;
      cmd          <= cmd_d;
      addr         <= addr_d;
      remaining    <= remaining_d;
      dly_cnt      <= dly_cnt_d;
      s_ready      <= s_ready_d;
      mem_we       <= mem_we_d;
      mem_sel      <= mem_sel_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      core_rst     <= core_rst_d;
      load_err     <= load_err_d;
      words_loaded <= words_loaded_d;
    end
  end

  always_comb begin
    state_d        = state;
    cmd_d          = cmd;
    addr_d         = addr;
    remaining_d    = remaining;
    dly_cnt_d      = dly_cnt;
    mem_we_d       = 1'b0;
    mem_sel_d      = mem_sel;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    core_rst_d     = core_rst;
    load_err_d     = load_err;
    words_loaded_d = words_loaded;

    case (state)
      HDR: if (accept) begin
        if (hdr_cmd == CMD_START) begin
          dly_cnt_d = '0;
          if (s_last) state_d = WAIT;
          else begin
            load_err_d = 1'b1;
            state_d    = DRAIN;
          end
        end else if (s_data[1:0] != 2'b00) begin
          load_err_d = 1'b1;
          state_d    = s_last ? HDR : DRAIN;
        end else if (s_last) begin
          load_err_d = 1'b1;
        end else begin
          cmd_d   = hdr_cmd;
          addr_d  = s_data[ADDR_W-1:0];
          state_d = LEN;
        end
      end
      LEN: if (accept) begin
        remaining_d = len_n;
        if (len_n == '0) begin
          if (s_last) state_d = HDR;
          else begin
            load_err_d = 1'b1;
            state_d    = DRAIN;
          end
        end else if (s_last) begin
          load_err_d = 1'b1;
          state_d    = HDR;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
        // Every accepted data word is written, including the word that
        // terminates a packet early or late.
        mem_we_d    = 1'b1;
        mem_sel_d   = cmd_to_sel(cmd);
        mem_addr_d  = addr;
        mem_wdata_d = s_data;
        addr_d      = addr + ADDR_W'(4);
        remaining_d = remaining - 1'b1;
        if (words_loaded != '1) words_loaded_d = words_loaded + 1'b1;
        if (remaining == CNT_W'(1)) begin
          if (s_last) state_d = HDR;
          else begin
            load_err_d = 1'b1;
            state_d    = DRAIN;
          end
        end else if (s_last) begin
          load_err_d = 1'b1;
          state_d    = HDR;
        end
      end
      DRAIN: if (accept && s_last) state_d = HDR;
      WAIT: begin
        // dly_cnt is 0 on the first WAIT edge, so the release lands exactly
        // START_DLY edges after the START accept.
        dly_cnt_d = dly_cnt + 1'b1;
        if (dly_cnt == 8'(START_DLY - 1)) begin
          core_rst_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN:     core_rst_d = 1'b1;
      default: state_d = HDR;
    endcase

    s_ready_d = (state_d == HDR) || (state_d == LEN) ||
                (state_d == DATA) || (state_d == DRAIN);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load packets into IM/DM/both, address wrap,
// protocol errors, reset mid-packet and START release timing.
module tb_prog_loader;
  import core_pkg::*;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned START_DLY = 4;
  localparam int unsigned CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;
  logic              mem_we;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              load_err;
  logic [CNT_W-1:0]  words_loaded;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  prog_loader #(
    .ADDR_W   (ADDR_W),
    .START_DLY(START_DLY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .mem_we      (mem_we),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word; waits (bounded) for s_ready, returns 1 ns after the
  // accepting edge so the registered write of that word is visible.
  task automatic send(input logic [31:0] data, input logic last);
    int unsigned waited = 0;
    while (!s_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("s_ready_wait", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [1:0] sel, input logic [31:0] wdata);
    check({tag, "_we"},    64'(mem_we),    64'd1);
    check({tag, "_addr"},  64'(mem_addr),  64'(addr));
    check({tag, "_sel"},   64'(mem_sel),   64'(sel));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata));
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready",  64'(s_ready),      64'd0);
    check("rst_mem_we",   64'(mem_we),       64'd0);
    check("rst_mem_sel",  64'(mem_sel),      64'd0);
    check("rst_mem_addr", 64'(mem_addr),     64'd0);
    check("rst_wdata",    64'(mem_wdata),    64'd0);
    check("rst_core_rst", 64'(core_rst),     64'd0);
    check("rst_load_err", 64'(load_err),     64'd0);
    check("rst_words",    64'(words_loaded), 64'd0);
    check("rst_state",    64'(dut.state),    64'(HDR));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1_words [3];
    logic [31:0] dm_words [3];
    logic [15:0] dm_addrs [3];
    t1_words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    dm_words = '{32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef};
    dm_addrs = '{16'hfff8, 16'hfffc, 16'h0000};

    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    tick(); tick();
    check_reset_vals();
    rst = 1'b1;
    tick();
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // IM @0x0000, N=3, back-to-back writes
    send(32'h0000_0000, 1'b0);
    check("t1_hdr_no_we", 64'(mem_we), 64'd0);
    send(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(t1_words[i], i == 2);
      check_write($sformatf("t1_w%0d", i), 16'(4 * i), 2'b01, t1_words[i]);
    end
    check("t1_words", 64'(words_loaded), 64'd3);
    tick();
    check("t1_we_drop", 64'(mem_we), 64'd0);
    check("t1_err", 64'(load_err), 64'd0);

    // DM @0xfff8, N=3, address wraps
    send(32'h4000_fff8, 1'b0);
    send(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(dm_words[i], i == 2);
      check_write($sformatf("wrap_w%0d", i), dm_addrs[i], 2'b10, dm_words[i]);
    end
    check("wrap_words", 64'(words_loaded), 64'd6);
    check("wrap_err", 64'(load_err), 64'd0);

    // IM N=4 with s_last on 2nd data word: 2 writes, error, back to HDR
    send(32'h0000_0200, 1'b0);
    send(32'd4, 1'b0);
    send(32'haaaa_0001, 1'b0);
    check_write("abort_w0", 16'h0200, 2'b01, 32'haaaa_0001);
    send(32'haaaa_0002, 1'b1);
    check_write("abort_w1", 16'h0204, 2'b01, 32'haaaa_0002);
    check("abort_err", 64'(load_err), 64'd1);
    check("abort_state", 64'(dut.state), 64'(HDR));
    // Next packet N=1 without s_last on its data word: written, then DRAIN
    send(32'h0000_0300, 1'b0);
    send(32'd1, 1'b0);
    send(32'hbbbb_0001, 1'b0);
    check_write("drain_w", 16'h0300, 2'b01, 32'hbbbb_0001);
    check("drain_state", 64'(dut.state), 64'(DRAIN));
    send(32'h0000_0000, 1'b0);
    check("drain_no_we0", 64'(mem_we), 64'd0);
    check("drain_hold", 64'(dut.state), 64'(DRAIN));
    send(32'h0000_0000, 1'b1);
    check("drain_no_we1", 64'(mem_we), 64'd0);
    check("drain_exit", 64'(dut.state), 64'(HDR));
    check("drain_words", 64'(words_loaded), 64'd9);

    // Reset mid-DATA after 2 of 5 words
    send(32'h0000_0400, 1'b0);
    send(32'd5, 1'b0);
    send(32'hcccc_0001, 1'b0);
    send(32'hcccc_0002, 1'b0);
    check_write("mid_w1", 16'h0404, 2'b01, 32'hcccc_0002);
    rst = 1'b0;
    tick();
    check_reset_vals();
    rst = 1'b1;
    send(32'h4000_0010, 1'b0);
    check("post_rst_hdr_no_we", 64'(mem_we), 64'd0);
    send(32'd1, 1'b0);
    send(32'h1111_2222, 1'b1);
    check_write("post_rst_w", 16'h0010, 2'b10, 32'h1111_2222);
    check("post_rst_words", 64'(words_loaded), 64'd1);
    check("post_rst_err", 64'(load_err), 64'd0);

    // Misaligned DM header: drained, no writes, error
    send(32'h4000_0002, 1'b0);
    check("mis_err", 64'(load_err), 64'd1);
    check("mis_state", 64'(dut.state), 64'(DRAIN));
    send(32'd2, 1'b0);
    check("mis_no_we0", 64'(mem_we), 64'd0);
    send(32'h5555_5555, 1'b0);
    check("mis_no_we1", 64'(mem_we), 64'd0);
    send(32'h6666_6666, 1'b1);
    check("mis_no_we2", 64'(mem_we), 64'd0);
    check("mis_words", 64'(words_loaded), 64'd1);
    send(32'h0000_0020, 1'b0);
    send(32'd1, 1'b0);
    send(32'h7777_8888, 1'b1);
    check_write("mis_next", 16'h0020, 2'b01, 32'h7777_8888);
    check("mis_next_words", 64'(words_loaded), 64'd2);

    // BOTH @0x9078, N=4 zeros
    send(32'h8000_9078, 1'b0);
    send(32'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(32'h0000_0000, i == 3);
      check_write($sformatf("both_w%0d", i), 16'(16'h9078 + 4 * i), 2'b11, 32'h0);
    end
    check("both_words", 64'(words_loaded), 64'd6);

    // START: core_rst rises exactly START_DLY edges after the accept
    send(32'hc000_0000, 1'b1);
    check("start_ready", 64'(s_ready), 64'd0);
    check("start_core_rst0", 64'(core_rst), 64'd0);
    for (int k = 1; k < START_DLY; k++) begin
      tick();
      check($sformatf("wait_core_rst_%0d", k), 64'(core_rst), 64'd0);
    end
    tick();
    check("core_rst_release", 64'(core_rst), 64'd1);
    check("run_state", 64'(dut.state), 64'(RUN));
    s_valid = 1'b1; s_data = 32'h1234_5678; s_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("run_ready_%0d", k), 64'(s_ready), 64'd0);
      check($sformatf("run_no_we_%0d", k), 64'(mem_we), 64'd0);
      check($sformatf("run_core_rst_%0d", k), 64'(core_rst), 64'd1);
    end
    s_valid = 1'b0;
    check("run_words", 64'(words_loaded), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for Core: accepts a 32-bit valid/ready word stream of load packets and writes the words into instruction memory, data memory, or both.
- Holds Core in reset until a START packet arrives, then releases it after a fixed settle delay.
- Replaces bench-side backdoor preloading (program image, preset data, zero-init words) with a synthesizable front-end.

Parameters:
- ADDR_W, 16, byte-address width of IM/DM (64 KiB space).
- START_DLY, 4, cycles from START accept to core_rst release (1..255).
- CNT_W, 16, width of the packet word-count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid&&s_ready
- s_data  in  32  stream word
- s_last  in  1  marks final word of a packet
- mem_we  out  1  write strobe, one cycle per word
- mem_sel  out  2  bit0 = IM, bit1 = DM
- mem_addr  out  ADDR_W  byte address, word aligned
- mem_wdata  out  32  little-endian word (byte0 -> mem_addr)
- core_rst  out  1  active-low reset to Core
- load_err  out  1  sticky protocol error
- words_loaded  out  CNT_W  total words written since reset, saturating

Behaviour:
- Reset (rst=0 at posedge): state=HDR, core_rst=0, s_ready=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, load_err=0, words_loaded=0. s_ready rises the cycle after reset deasserts.
- Header word: [31:30] cmd (00 IM, 01 DM, 10 IM+DM, 11 START); [ADDR_W-1:0] base address.
- States:
  - HDR: accept the header.
    - START with s_last=1 -> WAIT.
    - START with s_last=0 -> set load_err, go to DRAIN.
    - Load cmd with base[1:0]!=0 -> set load_err, go to DRAIN, or stay in HDR if s_last=1.
    - Load cmd with s_last=1 -> set load_err, stay in HDR.
    - Otherwise latch cmd and base, go to LEN.
  - LEN: accept N = s_data[CNT_W-1:0].
    - N=0 with s_last=1 -> HDR (empty packet, legal).
    - N=0 with s_last=0 -> set load_err, go to DRAIN.
    - N>0 with s_last=1 -> set load_err, go to HDR.
    - Otherwise go to DATA with remaining = N.
  - DATA: each accepted word is written.
    - Registered write: a word accepted at edge t gives mem_we=1 with addr/sel/wdata stable in cycle t+1.
    - Back-to-back accepts give back-to-back writes.
    - Address advances by 4 modulo 2^ADDR_W (0xfffc wraps to 0x0000).
    - Remaining decrements on each accepted word.
    - Last word (remaining=1) with s_last=1 -> HDR.
    - Last word with s_last=0 -> set load_err, go to DRAIN.
    - s_last=1 with remaining>1 -> write that word, set load_err, abort to HDR.
  - DRAIN: s_ready=1; discard words with no writes; s_last=1 -> HDR.
  - WAIT: s_ready=0; count START_DLY cycles, then core_rst=1 and go to RUN.
  - RUN: s_ready=0 forever; core_rst held 1; leave only via rst.
- mem_sel per cmd: 00 -> 01, 01 -> 10, 10 -> 11; in IM+DM mode one strobe writes both memories.
- s_ready is 1 in HDR, LEN, DATA and DRAIN. No internal backpressure: one word per cycle.
- words_loaded increments per write and saturates at all-ones. load_err clears only on reset.
- Reset mid-packet: the partial packet is dropped and the next word is treated as a header. Words already written are not undone.

Decomposition:
- Shared package (core_pkg): loader_cmd_e {CMD_IM, CMD_DM, CMD_BOTH, CMD_START}, loader_state_e {HDR, LEN, DATA, DRAIN, WAIT, RUN}, constants HDR_CMD_MSB=31, HDR_CMD_LSB=30.
- Single module; no sub-module is warranted. The memory write port is only a registered output bundle.

Test Plan:
- Packet IM @0x0000, N=3, words 0x00000013, 0x00100093, 0x00200113, last on the 3rd word -> IM writes at 0x0/0x4/0x8 on consecutive cycles, mem_sel=01, words_loaded=3, load_err=0.
- Packet BOTH @0x9078, N=4, all zero -> four writes 0x9078..0x9084 with mem_sel=11, then START packet -> core_rst rises exactly START_DLY cycles after the START accept; s_ready=0 from then on.
- Packet DM @0xfff8, N=3 -> writes at 0xfff8, 0xfffc, 0x0000 (wrap), mem_sel=10.
- Header DM @0x0002 (misaligned), N=2, 2 data words -> no writes, load_err=1, next valid packet loads normally.
- Packet IM N=4 with s_last on the 2nd data word -> 2 writes, load_err=1, state=HDR; a following packet with N=1 and no s_last on its data word -> state DRAIN until s_last.
- Assert rst=0 mid-DATA (after 2 of 5 words), release -> all outputs at reset values, core_rst=0, next word parsed as a header.
